// File: rtl/dm_store_rmw_pkg.sv
// Shared encodings for the store read-modify-write block: access sizes, FSM states
// and the alignment rule.
package dm_store_rmw_pkg;

  typedef logic [1:0] st_size_t;

  // Same encoding as the load extender's word_bit field; 3 is reserved and treated as word.
  localparam st_size_t SZ_WORD = 2'd0;
  localparam st_size_t SZ_HALF = 2'd1;
  localparam st_size_t SZ_BYTE = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic is_word(input st_size_t size);
    return (size != SZ_HALF) && (size != SZ_BYTE);
  endfunction

  function automatic logic is_misaligned(input st_size_t size, input logic [1:0] off);
    if (size == SZ_HALF)
      return off[0];
    else if (size == SZ_BYTE)
      return 1'b0;
    else
      return off != 2'b00;
  endfunction

endpackage

// File: rtl/dm_store_rmw_if.sv
// Store request (MEM stage side) and word-memory port bundled together.
// slave = the store block, master = pipeline plus memory environment.
interface dm_store_rmw_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [1:0]        st_size;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_done;
  logic              st_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  st_valid, st_size, st_addr, st_data, mem_rdata, mem_ack,
    output st_ready, st_done, st_err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output st_valid, st_size, st_addr, st_data, mem_rdata, mem_ack,
    input  st_ready, st_done, st_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_store_rmw_store_merge.sv
// Combinational lane merge: places right-aligned store data into the old memory word
// using little-endian byte lanes.
module store_merge
  import dm_store_rmw_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  input  logic [31:0] i_old,
  output logic [31:0] o_word
);

  logic w_word;
  assign w_word = is_word(i_size);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       w_sel;
      logic [7:0] w_src;

      assign w_sel = w_word
                  || ((i_size == SZ_HALF) && (i_off[1] == LANE[1]))
                  || ((i_size == SZ_BYTE) && (i_off == LANE));
      // A half store feeds lanes 0/2 from data[7:0] and lanes 1/3 from data[15:8].
      assign w_src = w_word               ? i_data[8*gi +: 8]
                   : (i_size == SZ_HALF)  ? i_data[8*(gi%2) +: 8]
                   :                        i_data[7:0];
      assign o_word[8*gi +: 8] = w_sel ? w_src : i_old[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dm_store_rmw.sv
// Store path into a word-wide data memory without byte enables: word stores are written
// directly, sub-word stores read-modify-write, misaligned stores are dropped with st_err.
module dm_store_rmw
  import dm_store_rmw_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  dm_store_rmw_if.slave  bus
);

  logic [1:0]        r_state;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [31:0]       r_data;
  logic [31:0]       r_wbuf;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-3:0] r_mem_addr;
  logic              r_done;
  logic              r_err;

  logic [31:0]       w_merged;
  logic              w_ack;

  store_merge u_merge (
    .i_size (r_size),
    .i_off  (r_off),
    .i_data (r_data),
    .i_old  (bus.mem_rdata),
    .o_word (w_merged)
  );

  assign w_ack = bus.mem_ack && r_mem_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_size     <= SZ_WORD;
      r_off      <= 2'b00;
      r_data     <= '0;
      r_wbuf     <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.st_valid) begin
            r_size <= bus.st_size;
            r_off  <= bus.st_addr[1:0];
            r_data <= bus.st_data;
            if (is_misaligned(bus.st_size, bus.st_addr[1:0])) begin
              r_state <= ST_RESP;
              r_err   <= 1'b1;
            end else begin
              r_state    <= is_word(bus.st_size) ? ST_WR : ST_RD;
              r_mem_req  <= 1'b1;
              r_mem_we   <= is_word(bus.st_size);
              r_mem_addr <= bus.st_addr[ADDR_W-1:2];
              if (is_word(bus.st_size))
                r_wbuf <= bus.st_data;
            end
          end
        end
        ST_RD: begin
          // mem_req stays high across the read-to-write turn; only we and wdata change.
          if (w_ack) begin
            r_wbuf   <= w_merged;
            r_mem_we <= 1'b1;
            r_state  <= ST_WR;
          end
        end
        ST_WR: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.st_ready  = (r_state == ST_IDLE);
  assign bus.st_done   = r_done;
  assign bus.st_err    = r_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_wbuf;

endmodule

// File: tb/tb_dm_store_rmw.sv
// Directed and randomized stores against a byte-addressed reference memory, with a
// word memory responder that models ack latency and spurious idle acks.
module tb_dm_store_rmw;
  import dm_store_rmw_pkg::*;

  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_store_rmw_if #(.ADDR_W(ADDR_W)) bus ();

  dm_store_rmw #(.ADDR_W(ADDR_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [1:0]  m_size;
  logic [1:0]  m_off;
  logic [31:0] m_data;
  logic [31:0] m_old;
  logic [31:0] m_out;

  store_merge u_merge (
    .i_size (m_size),
    .i_off  (m_off),
    .i_data (m_data),
    .i_old  (m_old),
    .o_word (m_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_words [0:255];
  logic [7:0]  ref_bytes [0:1023];
  int          ack_delay = 0;
  logic        spur_ack = 1'b0;
  int          n_reads = 0;
  int          n_writes = 0;
  int          n_req_cycles = 0;
  int          wr_ack_cyc = 0;
  logic [31:0] last_wdata = '0;
  logic [29:0] last_waddr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int wa, input logic [31:0] v);
    mem_words[wa] = v;
    for (int i = 0; i < 4; i++) ref_bytes[4*wa + i] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int wa);
    return {ref_bytes[4*wa+3], ref_bytes[4*wa+2], ref_bytes[4*wa+1], ref_bytes[4*wa]};
  endfunction

  // Memory responder: acks after ack_delay waiting cycles per phase, checks request stability.
  initial begin : responder
    int          ph_cnt;
    logic [29:0] ph_addr;
    logic        ph_we;
    logic [31:0] ph_wdata;
    ph_cnt = 0;
    ph_addr = '0;
    ph_we = 1'b0;
    ph_wdata = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        n_req_cycles++;
        if (ph_cnt == 0) begin
          ph_addr = bus.mem_addr;
          ph_we = bus.mem_we;
          ph_wdata = bus.mem_wdata;
        end else begin
          chk("req_stable_addr", 32'(bus.mem_addr), 32'(ph_addr));
          chk("req_stable_we", 32'(bus.mem_we), 32'(ph_we));
          if (ph_we) chk("req_stable_wdata", bus.mem_wdata, ph_wdata);
        end
        if (ph_cnt >= ack_delay) begin
          bus.mem_ack = 1'b1;
          ph_cnt = 0;
          if (bus.mem_we) begin
            mem_words[bus.mem_addr[7:0]] = bus.mem_wdata;
            n_writes++;
            wr_ack_cyc = cyc + 1;
            last_wdata = bus.mem_wdata;
            last_waddr = bus.mem_addr;
          end else begin
            bus.mem_rdata = mem_words[bus.mem_addr[7:0]];
            n_reads++;
          end
        end else begin
          ph_cnt++;
        end
      end else begin
        ph_cnt = 0;
        bus.mem_ack = spur_ack;
      end
    end
  end

  // Issues one store from just after a negedge and returns at the negedge after its response.
  task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] data, output int resp_cyc);
    int   k, nb, rd0, wr0, rq0, acc, base;
    logic mis;
    k = 0;
    while (bus.st_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_store", 32'(bus.st_ready), 32'd1);
    nb = (size == SZ_HALF) ? 2 : (size == SZ_BYTE) ? 1 : 4;
    mis = (int'(addr[1:0]) % nb) != 0;
    rd0 = n_reads;
    wr0 = n_writes;
    rq0 = n_req_cycles;
    bus.st_valid = 1'b1;
    bus.st_size = size;
    bus.st_addr = addr;
    bus.st_data = data;
    @(posedge clk);
    @(negedge clk);
    bus.st_valid = 1'b0;
    bus.st_data = $urandom;
    acc = cyc;
    k = 0;
    while (bus.st_done !== 1'b1 && bus.st_err !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    resp_cyc = cyc;
    if (mis) begin
      chk("err_pulse", 32'(bus.st_err), 32'd1);
      chk("err_no_done", 32'(bus.st_done), 32'd0);
      chk("err_latency", 32'(cyc - acc), 32'd0);
      chk("err_no_mem_req", 32'(n_req_cycles - rq0), 32'd0);
    end else begin
      chk("done_pulse", 32'(bus.st_done), 32'd1);
      chk("done_no_err", 32'(bus.st_err), 32'd0);
      chk("done_after_wr_ack", 32'(cyc), 32'(wr_ack_cyc));
      chk("read_count", 32'(n_reads - rd0), (nb == 4) ? 32'd0 : 32'd1);
      chk("write_count", 32'(n_writes - wr0), 32'd1);
      chk("write_addr", 32'(last_waddr), 32'(addr[31:2]));
      base = int'(addr[9:0]);
      for (int i = 0; i < nb; i++) ref_bytes[base + i] = data[8*i +: 8];
      chk("write_data", last_wdata, ref_word(base / 4));
      chk("mem_word", mem_words[base / 4], ref_word(base / 4));
    end
    $display("store size=%0d addr=%h data=%h -> %s word=%h", size, addr, data,
             mis ? "err" : "done", mem_words[addr[9:2]]);
    @(negedge clk);
    chk("pulse_single_done", 32'(bus.st_done), 32'd0);
    chk("pulse_single_err", 32'(bus.st_err), 32'd0);
    chk("ready_after_resp", 32'(bus.st_ready), 32'd1);
  endtask

  initial begin : stim
    int d0, d1, d2, d3, rq0;
    int nb;
    logic [7:0] b [4];
    reset = 1'b0;
    bus.st_valid = 1'b0;
    bus.st_size = SZ_WORD;
    bus.st_addr = '0;
    bus.st_data = '0;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_done", 32'(bus.st_done), 32'd0);
    chk("rst_err", 32'(bus.st_err), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed sub-word cases on a known word.
    set_word(32'h40, 32'h11223344);
    do_store(SZ_BYTE, 32'h101, 32'h000000AB, d0);
    chk("tp_sb_0x101", mem_words[32'h40], 32'h1122AB44);
    set_word(32'h40, 32'h11223344);
    do_store(SZ_HALF, 32'h102, 32'h0000BEEF, d0);
    chk("tp_sh_0x102", mem_words[32'h40], 32'hBEEF3344);
    set_word(32'h40, 32'h11223344);
    do_store(SZ_HALF, 32'h100, 32'h0000BEEF, d0);
    chk("tp_sh_0x100", mem_words[32'h40], 32'h1122BEEF);

    // Word store with slow memory: three request cycles.
    ack_delay = 2;
    rq0 = n_req_cycles;
    do_store(SZ_WORD, 32'h104, 32'hDEADBEEF, d0);
    chk("tp_sw_req_cycles", 32'(n_req_cycles - rq0), 32'd3);
    chk("tp_sw_word", mem_words[32'h41], 32'hDEADBEEF);
    ack_delay = 0;

    do_store(SZ_HALF, 32'h103, 32'h00001234, d0);
    do_store(SZ_WORD, 32'h102, 32'h12345678, d0);
    do_store(2'd3, 32'h101, 32'h0BADF00D, d0);

    // Asynchronous reset while the read is outstanding.
    ack_delay = 100;
    bus.st_valid = 1'b1;
    bus.st_size = SZ_BYTE;
    bus.st_addr = 32'h105;
    bus.st_data = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    bus.st_valid = 1'b0;
    chk("abort_req_high", 32'(bus.mem_req), 32'd1);
    chk("abort_is_read", 32'(bus.mem_we), 32'd0);
    #2 reset = 1'b0;
    #1 chk("abort_req_drops", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 32'(bus.st_done), 32'd0);
      chk("abort_no_err", 32'(bus.st_err), 32'd0);
      @(negedge clk);
    end
    chk("abort_ready", 32'(bus.st_ready), 32'd1);
    chk("abort_mem_untouched", mem_words[32'h41], ref_word(32'h41));
    do_store(SZ_BYTE, 32'h105, 32'h0000005A, d0);

    // Back-to-back byte stores with zero-wait memory.
    set_word(32'h40, 32'hFFFFFFFF);
    do_store(SZ_BYTE, 32'h100, 32'h01, d0);
    do_store(SZ_BYTE, 32'h101, 32'h02, d1);
    do_store(SZ_BYTE, 32'h102, 32'h03, d2);
    do_store(SZ_BYTE, 32'h103, 32'h04, d3);
    chk("b2b_word", mem_words[32'h40], 32'h04030201);
    chk("b2b_gap1", 32'(d1 - d0), 32'd4);
    chk("b2b_gap2", 32'(d2 - d1), 32'd4);
    chk("b2b_gap3", 32'(d3 - d2), 32'd4);
    do_store(SZ_WORD, 32'h108, 32'hCAFEF00D, d0);
    do_store(SZ_WORD, 32'h10C, 32'h0D15EA5E, d1);
    chk("b2b_word_gap", 32'(d1 - d0), 32'd3);

    // Lane merge on its own: all legal size/offset pairs.
    for (int s = 0; s < 3; s++) begin
      nb = (s == 0) ? 4 : (s == 1) ? 2 : 1;
      for (int off = 0; off < 4; off += nb) begin
        m_size = 2'(s);
        m_off = 2'(off);
        m_data = $urandom;
        m_old = $urandom;
        for (int i = 0; i < 4; i++) b[i] = m_old[8*i +: 8];
        for (int i = 0; i < nb; i++) b[off + i] = m_data[8*i +: 8];
        #1;
        chk($sformatf("merge_s%0d_o%0d", s, off), m_out, {b[3], b[2], b[1], b[0]});
        $display("merge size=%0d off=%0d data=%h old=%h -> %h", s, off, m_data, m_old, m_out);
      end
    end
    @(negedge clk);

    // Randomized stores with variable latency and spurious idle acks.
    for (int n = 0; n < 60; n++) begin
      ack_delay = $urandom_range(0, 3);
      spur_ack = 1'($urandom_range(0, 1));
      do_store(2'($urandom_range(0, 3)), 32'h100 + 32'($urandom_range(0, 63)), $urandom, d0);
    end
    spur_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_store_rmw.md
# dm_store_rmw

Store-side partner of the load extender: it takes store requests (sw/sh/sb) from the MEM stage and writes them into a word-wide data memory that has no byte enables. Sub-word stores use a read-modify-write sequence. Word stores are written directly. Misaligned stores are flagged and never reach memory. The block sits between the MEM stage and the DM port and stalls the pipeline while busy.

## Interface
Parameters:
- ADDR_W, 32: byte-address width; memory word address is ADDR_W-2 bits.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- st_valid  in  1  MEM stage presents a store.
- st_ready  out  1  block can accept a store; high only in IDLE.
- st_size  in  2  0 = word, 1 = half, 2 = byte; 3 is reserved and treated as word.
- st_addr  in  ADDR_W  byte address.
- st_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- st_done  out  1  one-cycle pulse when the store is committed to memory.
- st_err  out  1  one-cycle pulse when the store is misaligned and dropped.
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read word; valid in the mem_ack cycle of a read.
- mem_ack  in  1  completes the current request; sampled only while mem_req is high.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE:
  - st_ready = 1.
  - On st_valid, latch size, addr, data.
  - If misaligned, go to RESP with the error flag set. Misaligned means half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Otherwise, a word store goes to WR with wbuf = st_data.
  - Otherwise, a half or byte store goes to RD.
- RD:
  - mem_req = 1, mem_we = 0, mem_addr = addr[ADDR_W-1:2].
  - On mem_ack, merge into wbuf and go to WR. Little-endian lanes:
    - byte lane = addr[1:0], bits [8k+7:8k] ← data[7:0], rest from mem_rdata.
    - half lane = addr[1], bits [31:16] when addr[1] = 1, else [15:0].
- WR:
  - mem_req = 1, mem_we = 1, same mem_addr, mem_wdata = wbuf.
  - On mem_ack, go to RESP with the error flag clear.
- RESP:
  - Pulse st_done, or st_err if the error flag is set.
  - Go to IDLE.
  - Exactly one of st_done or st_err pulses per accepted store.
- Every output is registered except st_ready, which is decoded from state.
- mem_addr, mem_we and mem_wdata stay stable while mem_req is high.
- Reset values: state = IDLE, st_done = 0, st_err = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, wbuf = 0.
- Reset mid-operation: mem_req drops immediately (asynchronous), the request is discarded, and no done or err is produced.
- mem_ack outside RD or WR, or while mem_req is low, is ignored.
- st_valid while st_ready = 0 is ignored; the MEM stage holds its request.

## Timing
- Store accepted at edge T0, the first edge where st_valid = 1 and st_ready = 1.
- Word store:
  - mem_req high from T0+; write ack at edge Ta (Ta ≥ T0+1).
  - st_done high for the cycle after Ta.
  - Best case: 3 cycles accept-to-accept.
- Sub-word store:
  - Read ack at edge Tr, write request from Tr+, write ack at Tw.
  - st_done in the cycle after Tw.
  - Best case: 4 cycles accept-to-accept.
- Misaligned store: st_err in the cycle after T0, with zero memory requests.
- Zero-wait memory (ack tied high during request) completes each memory phase in one cycle.

## Structure
- Shared package constants: the size encodings SZ_WORD = 0, SZ_HALF = 1, SZ_BYTE = 2, matching the load extender's word_bit encoding, and the state encoding.
- One natural sub-module, `store_merge`, which is combinational: (size, addr[1:0], data, old word) → merged word.
  - The FSM and handshake live in `dm_store_rmw`.
  - `store_merge` is unit-tested on its own against all 7 legal size/offset combinations.

## Test plan
- Memory[0x100] = 0x11223344; sb 0xAB at 0x101 → one read, then a write of 0x1122AB44; st_done once; st_err stays 0.
- Same initial word; sh 0xBEEF at 0x102 → write 0xBEEF3344. sh 0xBEEF at 0x100 → write 0x1122BEEF.
- sw 0xDEADBEEF at 0x104 with 3-cycle ack delay → no read issued; mem_req held 3 cycles with stable addr 0x41 and data; st_done the cycle after ack.
- sh at 0x103 and sw at 0x102 → st_err pulse the cycle after accept; mem_req never rises; st_ready returns the next cycle.
- reset asserted during RD with mem_req high → mem_req low immediately; after release state is IDLE and no st_done appears; the next sb completes normally.
- Back-to-back sb 0x01..0x04 to 0x100..0x103 with zero-wait memory → final word 0x04030201; exactly 4 st_done pulses, 4 cycles apart.
